// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and defaults for the branch resolution controller.
// The index field is sized for the widest supported table (IDX_W up to 8).
package branch_ctrl_pkg;

    localparam int DEF_DEPTH        = 4;
    localparam int DEF_IDX_W        = 5;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int IDX_MAX_W        = 8;
    localparam int FCNT_W           = 3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] index;
        logic                 taken;
        logic [31:0]          target;
        logic [31:0]          fallthru;
    } bp_entry_t;

    // A taken/taken pair still mispredicts when the targets disagree.
    function automatic logic is_mispredict(bp_entry_t h, logic res_taken, logic [31:0] res_target);
        return (res_taken != h.taken) || (res_taken && (res_target != h.target));
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bus between IF predictor / EX branch unit and the resolution controller.
// Stats outputs exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_ctrl_if
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = DEF_IDX_W
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // Prediction handshake: a prediction is transferred on a rising edge where
    // pred_valid && pred_ready; pred_valid does not depend on pred_ready.
    logic              pred_valid;
    logic              pred_ready;
    logic [IDX_W-1:0]  pred_index;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic [31:0]       pred_fallthru;

    logic              res_valid;
    logic              res_taken;
    logic [31:0]       res_target;

    logic              upd_valid;
    logic [IDX_W-1:0]  upd_index;
    logic              upd_taken;
    logic              flush;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [OCC_W-1:0]  occupancy;
    logic              err_underflow;
    ctrl_state_t       dbg_state;
`ifdef BRANCH_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;
`endif

    modport master (
        output pred_valid, pred_index, pred_taken, pred_target, pred_fallthru,
        output res_valid, res_taken, res_target,
        input  pred_ready, upd_valid, upd_index, upd_taken, flush,
        input  redirect_valid, redirect_pc, occupancy, err_underflow, dbg_state
`ifdef BRANCH_STATS_EN
        , input stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  pred_valid, pred_index, pred_taken, pred_target, pred_fallthru,
        input  res_valid, res_taken, res_target,
        output pred_ready, upd_valid, upd_index, upd_taken, flush,
        output redirect_valid, redirect_pc, occupancy, err_underflow, dbg_state
`ifdef BRANCH_STATS_EN
        , output stat_branches, stat_mispredicts
`endif
    );

endinterface

// File: rtl/branch_resolve_ctrl_fifo.sv
// In-order queue of pending branch predictions with a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module branch_pred_fifo
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  bp_entry_t        din,
    output bp_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves queued IF predictions against EX outcomes: predictor update, flush, redirect.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input logic                 clk,
    input logic                 reset,
    branch_resolve_ctrl_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    ctrl_state_t       state_q, state_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;

    bp_entry_t         push_entry;
    bp_entry_t         head;
    logic [OCC_W-1:0]  count;
    logic              full;
    logic              empty;

    logic              running;
    logic              pred_ready;
    logic              push_acc;
    logic              pop;
    logic              mispredict;
    logic              underflow;

    logic              upd_valid_q;
    logic [IDX_W-1:0]  upd_index_q;
    logic              upd_taken_q;
    logic              redirect_valid_q;
    logic [31:0]       redirect_pc_q;
    logic              err_underflow_q;
    logic              flush;

    assign running    = (state_q == RUN);
    assign push_acc   = bus.pred_valid && pred_ready;
    assign pop        = bus.res_valid && running && !empty;
    assign underflow  = bus.res_valid && running && empty;
    assign mispredict = pop && is_mispredict(head, bus.res_taken, bus.res_target);

    assign push_entry.index    = IDX_MAX_W'(bus.pred_index);
    assign push_entry.taken    = bus.pred_taken;
    assign push_entry.target   = bus.pred_target;
    assign push_entry.fallthru = bus.pred_fallthru;

    // Clearing on mispredict drops the younger wrong-path entries and any same-edge push.
    branch_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_acc),
        .pop   (pop),
        .clear (mispredict),
        .din   (push_entry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    cnt_d   = FCNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - FCNT_W'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        flush      = (state_q == FLUSH);
        pred_ready = running && !full;
    end

    // Resolution results land one cycle after the res_valid edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_q      <= 1'b0;
            upd_index_q      <= '0;
            upd_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            err_underflow_q  <= 1'b0;
        end else begin
            upd_valid_q      <= pop;
            redirect_valid_q <= mispredict;
            if (pop) begin
                upd_index_q <= head.index[IDX_W-1:0];
                upd_taken_q <= bus.res_taken;
            end
            if (mispredict)
                redirect_pc_q <= bus.res_taken ? bus.res_target : head.fallthru;
            if (underflow)
                err_underflow_q <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (pop && (stat_br_q != '1))         stat_br_q  <= stat_br_q + 32'd1;
            if (mispredict && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mis_q;
`endif

    assign bus.pred_ready     = pred_ready;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_index      = upd_index_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.flush          = flush;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.occupancy      = count;
    assign bus.err_underflow  = err_underflow_q;
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed literal checks, then random traffic
// compared every cycle against a queue-based model of the resolution rules.
module tb_branch_resolve_ctrl;
    import branch_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDX_W = 5;
    localparam int FC    = 2;

    logic clk;
    logic reset;

    branch_resolve_ctrl_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bif ();

    branch_resolve_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             tk;
        logic [31:0]      tgt;
        logic [31:0]      fall;
    } m_ent_t;

    m_ent_t      exp_q[$];
    int          m_fl;
    bit          m_err, m_uv, m_ut, m_rv, chk_en;
    logic [IDX_W-1:0] m_ui;
    logic [31:0] m_rpc, m_br, m_mis;
    m_ent_t      m_h;
    bit          m_ready, m_miss;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds pending predictions; m_fl counts flush cycles left.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_fl = 0; m_err = 0; m_uv = 0; m_ut = 0; m_ui = '0;
            m_rv = 0; m_rpc = '0; m_br = '0; m_mis = '0;
            chk_en = 1;
        end else begin
            m_ready = (m_fl == 0) && (exp_q.size() < DEPTH);
            m_miss = 0; m_uv = 0; m_rv = 0;
            if (m_fl > 0) begin
                m_fl--;
            end else begin
                if (bif.res_valid) begin
                    if (exp_q.size() == 0) begin
                        m_err = 1;
                    end else begin
                        m_h = exp_q.pop_front();
                        m_uv = 1; m_ui = m_h.idx; m_ut = bif.res_taken;
                        if (m_br != 32'hFFFFFFFF) m_br++;
                        m_miss = (bif.res_taken != m_h.tk) ||
                                 (bif.res_taken && m_h.tk && (bif.res_target != m_h.tgt));
                        if (m_miss) begin
                            exp_q.delete();
                            m_fl = FC;
                            m_rv = 1;
                            m_rpc = bif.res_taken ? bif.res_target : m_h.fall;
                            if (m_mis != 32'hFFFFFFFF) m_mis++;
                        end
                    end
                end
                if (bif.pred_valid && m_ready && !m_miss)
                    exp_q.push_back('{bif.pred_index, bif.pred_taken, bif.pred_target, bif.pred_fallthru});
            end
        end
    end

    // Compare process, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pred_ready", 32'(bif.pred_ready), 32'((m_fl == 0) && (exp_q.size() < DEPTH)));
            cmp("occupancy", 32'(bif.occupancy), 32'(exp_q.size()));
            cmp("flush", 32'(bif.flush), 32'(m_fl > 0));
            cmp("upd_valid", 32'(bif.upd_valid), 32'(m_uv));
            cmp("redirect_valid", 32'(bif.redirect_valid), 32'(m_rv));
            cmp("err_underflow", 32'(bif.err_underflow), 32'(m_err));
            if (m_uv) begin
                cmp("upd_index", 32'(bif.upd_index), 32'(m_ui));
                cmp("upd_taken", 32'(bif.upd_taken), 32'(m_ut));
            end
            if (m_rv) cmp("redirect_pc", bif.redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
            cmp("stat_branches", bif.stat_branches, m_br);
            cmp("stat_mispredicts", bif.stat_mispredicts, m_mis);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.pred_valid = 0; bif.pred_index = '0; bif.pred_taken = 0;
        bif.pred_target = '0; bif.pred_fallthru = '0;
        bif.res_valid = 0; bif.res_taken = 0; bif.res_target = '0;
    endtask

    task automatic push(input int idx, input logic tk, input logic [31:0] tgt, input logic [31:0] fall);
        bif.pred_valid = 1; bif.pred_index = IDX_W'(idx); bif.pred_taken = tk;
        bif.pred_target = tgt; bif.pred_fallthru = fall;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        bif.res_valid = 1; bif.res_taken = tk; bif.res_target = tgt;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        chk_en = 0;
        reset = 1;
        idle();
        tick(); tick();
        reset = 0;
        cmp("rst pred_ready", 32'(bif.pred_ready), 32'd1);
        cmp("rst flush", 32'(bif.flush), 32'd0);
        cmp("rst occupancy", 32'(bif.occupancy), 32'd0);
        cmp("rst upd_valid", 32'(bif.upd_valid), 32'd0);

        // Correct not-taken prediction
        push(5, 0, 32'h500, 32'h104); tick();
        idle(); resolve(0, 32'h0); tick();
        idle();
        cmp("ok upd_valid", 32'(bif.upd_valid), 32'd1);
        cmp("ok upd_index", 32'(bif.upd_index), 32'd5);
        cmp("ok upd_taken", 32'(bif.upd_taken), 32'd0);
        cmp("ok flush", 32'(bif.flush), 32'd0);
        cmp("ok redirect_valid", 32'(bif.redirect_valid), 32'd0);

        // Direction mispredict with a younger wrong-path entry queued
        push(3, 0, 32'h280, 32'h204); tick();
        push(7, 0, 32'h380, 32'h304); tick();
        idle(); resolve(1, 32'h300); tick();
        idle();
        cmp("mp redirect_valid", 32'(bif.redirect_valid), 32'd1);
        cmp("mp redirect_pc", bif.redirect_pc, 32'h300);
        cmp("mp upd_index", 32'(bif.upd_index), 32'd3);
        cmp("mp upd_taken", 32'(bif.upd_taken), 32'd1);
        cmp("mp flush c0", 32'(bif.flush), 32'd1);
        cmp("mp pred_ready c0", 32'(bif.pred_ready), 32'd0);
        cmp("mp occupancy", 32'(bif.occupancy), 32'd0);
        tick();
        cmp("mp flush c1", 32'(bif.flush), 32'd1);
        cmp("mp redirect c1", 32'(bif.redirect_valid), 32'd0);
        cmp("mp pred_ready c1", 32'(bif.pred_ready), 32'd0);
        tick();
        cmp("mp flush done", 32'(bif.flush), 32'd0);
        cmp("mp pred_ready done", 32'(bif.pred_ready), 32'd1);

        // Target mispredict, then taken-predicted but not taken
        push(9, 1, 32'h400, 32'h40c); tick();
        idle(); resolve(1, 32'h480); tick();
        idle();
        cmp("tgt redirect_pc", bif.redirect_pc, 32'h480);
        tick(); tick();
        push(10, 1, 32'h500, 32'h50c); tick();
        idle(); resolve(0, 32'h0); tick();
        idle();
        cmp("nt redirect_valid", 32'(bif.redirect_valid), 32'd1);
        cmp("nt redirect_pc", bif.redirect_pc, 32'h50c);
        tick(); tick();

        // Fill, overfill, then streaming push+pop across the pointer wrap
        for (int i = 1; i <= 4; i++) begin
            push(i, 0, 32'h0, 32'h1000 + 32'(i)); tick();
        end
        cmp("full pred_ready", 32'(bif.pred_ready), 32'd0);
        cmp("full occupancy", 32'(bif.occupancy), 32'd4);
        push(20, 0, 32'h0, 32'h2000); tick();
        cmp("overfill occupancy", 32'(bif.occupancy), 32'd4);
        resolve(0, 32'h0); tick();
        cmp("popfull upd_index", 32'(bif.upd_index), 32'd1);
        cmp("popfull occupancy", 32'(bif.occupancy), 32'd3);
        push(21, 0, 32'h0, 32'h2100); tick();
        cmp("stream upd_index a", 32'(bif.upd_index), 32'd2);
        cmp("stream occupancy a", 32'(bif.occupancy), 32'd3);
        push(22, 0, 32'h0, 32'h2200); tick();
        cmp("stream upd_index b", 32'(bif.upd_index), 32'd3);
        cmp("stream occupancy b", 32'(bif.occupancy), 32'd3);
        bif.pred_valid = 0;
        tick(); cmp("drain idx 4", 32'(bif.upd_index), 32'd4);
        tick(); cmp("drain idx 21", 32'(bif.upd_index), 32'd21);
        tick(); cmp("drain idx 22", 32'(bif.upd_index), 32'd22);
        cmp("drain occupancy", 32'(bif.occupancy), 32'd0);

        // Underflow is sticky and produces no update
        tick();
        cmp("uf err", 32'(bif.err_underflow), 32'd1);
        cmp("uf upd_valid", 32'(bif.upd_valid), 32'd0);
        idle(); tick();
        cmp("uf sticky", 32'(bif.err_underflow), 32'd1);

        // Reset in the middle of a flush
        push(1, 0, 32'h0, 32'h700); tick();
        idle(); resolve(1, 32'h600); tick();
        idle();
        cmp("rf flush", 32'(bif.flush), 32'd1);
        reset = 1; tick(); reset = 0;
        cmp("rf flush cleared", 32'(bif.flush), 32'd0);
        cmp("rf err cleared", 32'(bif.err_underflow), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            bif.pred_valid    = ($urandom_range(0, 1) == 1);
            bif.pred_index    = IDX_W'($urandom_range(0, 31));
            bif.pred_taken    = 1'($urandom_range(0, 1));
            bif.pred_target   = 32'h1000 + 32'($urandom_range(0, 2)) * 4;
            bif.pred_fallthru = $urandom();
            bif.res_valid     = ($urandom_range(0, 9) < 4);
            bif.res_taken     = 1'($urandom_range(0, 1));
            bif.res_target    = 32'h1000 + 32'($urandom_range(0, 2)) * 4;
            tick();
        end
        reset = 0;
        idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
